// File: rtl/dram_arb_pkg.sv
// Shared types for the DRAM arbiter: FSM states, op encoding and default widths.
package dram_arb_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage

// File: rtl/dram_arbiter_rr_pick.sv
// Combinational winner picker: round-robin from last_grant+1, or lowest index
// when DRAM_ARB_FIXED_PRIO_EN is defined.
module rr_pick #(
  parameter int NUM_CORES = 2,
  parameter int GW        = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [GW-1:0]        last_grant,
  output logic [GW-1:0]        grant,
  output logic                 any_req
);

`ifdef DRAM_ARB_FIXED_PRIO_EN
  logic unused_lg;
  assign unused_lg = ^last_grant;

  always_comb begin
    grant   = '0;
    any_req = |req;
    for (int k = NUM_CORES - 1; k >= 0; k--)
      if (req[k]) grant = GW'(k);
  end
`else
  always_comb begin
    int  idx;
    logic found;
    grant   = '0;
    any_req = |req;
    found   = 1'b0;
    idx     = 0;
    // last_grant <= NUM_CORES-1, so one subtraction is enough for the wrap
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = int'(last_grant) + 1 + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (!found && req[idx]) begin
        grant = GW'(idx);
        found = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/dram_arbiter.sv
// N-core arbiter in front of a single-port synchronous DRAM (1-cycle read latency).
// Optional DRAM_ARB_FIXED_PRIO_EN swaps round-robin for fixed lowest-index priority.
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int NUM_CORES = 2,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic                          CLK,
  input  logic                          rst,
  input  logic [NUM_CORES-1:0]          rden,
  input  logic [NUM_CORES-1:0]          wren,
  input  logic [NUM_CORES*ADDR_W-1:0]   Address,
  input  logic [NUM_CORES*DATA_W-1:0]   Din,
  input  logic [DATA_W-1:0]             RAMq,
  output logic [NUM_CORES-1:0]          acq,
  output logic [NUM_CORES*DATA_W-1:0]   Dq,
  output logic [ADDR_W-1:0]             RAMAddress,
  output logic [DATA_W-1:0]             RAMDin,
  output logic                          RAMwren
);

  localparam int GW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  state_t state, state_nx;

  logic [NUM_CORES-1:0][ADDR_W-1:0] addr_v;
  logic [NUM_CORES-1:0][DATA_W-1:0] din_v;
  logic [NUM_CORES-1:0][DATA_W-1:0] dq_r;

  logic [GW-1:0]     last_grant, lat_g, pick_g;
  logic              any_req;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_din;
  op_t               lat_op;

  assign addr_v = Address;
  assign din_v  = Din;
  assign Dq     = dq_r;

  rr_pick #(.NUM_CORES(NUM_CORES), .GW(GW)) u_pick (
    .req        (rden | wren),
    .last_grant (last_grant),
    .grant      (pick_g),
    .any_req    (any_req)
  );

  // Latched registers only change on the IDLE sample edge, so they double as the
  // hold-last-value DRAM address/data bus.
  assign RAMAddress = lat_addr;
  assign RAMDin     = lat_din;
  assign RAMwren    = (state == ST_ACCESS) && (lat_op == OP_WRITE) && !rst;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (any_req) state_nx = ST_ACCESS;
      ST_ACCESS:  state_nx = (lat_op == OP_WRITE) ? ST_IDLE : ST_CAPTURE;
      ST_CAPTURE: state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state      <= ST_IDLE;
      acq        <= '0;
      dq_r       <= '0;
      last_grant <= GW'(NUM_CORES - 1);
      lat_g      <= '0;
      lat_addr   <= '0;
      lat_din    <= '0;
      lat_op     <= OP_READ;
    end else begin
      state <= state_nx;
      acq   <= '0;
      case (state)
        ST_IDLE: if (any_req) begin
          lat_g      <= pick_g;
          lat_addr   <= addr_v[pick_g];
          lat_din    <= din_v[pick_g];
          lat_op     <= wren[pick_g] ? OP_WRITE : OP_READ;
          last_grant <= pick_g;
        end
        ST_ACCESS: if (lat_op == OP_WRITE) acq[lat_g] <= 1'b1;
        ST_CAPTURE: begin
          dq_r[lat_g] <= RAMq;
          acq[lat_g]  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench: a 2-core and a 4-core arbiter, each with a behavioural DRAM.
module tb_dram_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // ---- 2-core instance ----
  logic [1:0]      rden2, wren2, acq2;
  logic [1:0][7:0] addr2, din2, dq2;
  logic [7:0]      q2, ra2, rd2;
  logic            we2;
  logic [7:0]      mem2 [256];
  logic            pl2_en;
  logic [7:0]      pl2_a, pl2_d;

  dram_arbiter #(.NUM_CORES(2), .ADDR_W(8), .DATA_W(8)) d2 (
    .CLK(clk), .rst(rst), .rden(rden2), .wren(wren2), .Address(addr2), .Din(din2),
    .RAMq(q2), .acq(acq2), .Dq(dq2), .RAMAddress(ra2), .RAMDin(rd2), .RAMwren(we2)
  );

  always @(posedge clk) begin
    if (pl2_en) mem2[pl2_a] <= pl2_d;
    else if (we2) mem2[ra2] <= rd2;
    q2 <= mem2[ra2];
  end

  // ---- 4-core instance ----
  logic [3:0]      rden4, wren4, acq4;
  logic [3:0][7:0] addr4, din4, dq4;
  logic [7:0]      q4, ra4, rd4;
  logic            we4;
  logic [7:0]      mem4 [256];
  logic            pl4_en;
  logic [7:0]      pl4_a, pl4_d;

  dram_arbiter #(.NUM_CORES(4), .ADDR_W(8), .DATA_W(8)) d4 (
    .CLK(clk), .rst(rst), .rden(rden4), .wren(wren4), .Address(addr4), .Din(din4),
    .RAMq(q4), .acq(acq4), .Dq(dq4), .RAMAddress(ra4), .RAMDin(rd4), .RAMwren(we4)
  );

  always @(posedge clk) begin
    if (pl4_en) mem4[pl4_a] <= pl4_d;
    else if (we4) mem4[ra4] <= rd4;
    q4 <= mem4[ra4];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic poke2(input logic [7:0] a, input logic [7:0] d);
    pl2_en = 1'b1; pl2_a = a; pl2_d = d;
    tick;
    pl2_en = 1'b0;
  endtask

  task automatic poke4(input logic [7:0] a, input logic [7:0] d);
    pl4_en = 1'b1; pl4_a = a; pl4_d = d;
    tick;
    pl4_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rden2 = '0; wren2 = '0; addr2 = '0; din2 = '0;
    rden4 = '0; wren4 = '0; addr4 = '0; din4 = '0;
    pl2_en = 1'b0; pl2_a = '0; pl2_d = '0;
    pl4_en = 1'b0; pl4_a = '0; pl4_d = '0;
    tick;
    poke2(8'h10, 8'hA5);
    poke2(8'h22, 8'h00);
    poke2(8'h50, 8'h11);
    for (int i = 0; i < 4; i++) poke4(8'h40 + 8'(i), 8'hB0 + 8'(i));
    rst = 1'b0;
    tick;
    total_cnt++; if (acq2 !== 2'b00) $display("FAIL reset_acq2 got %b want 00", acq2); else pass_cnt++;
    total_cnt++; if (dq2 !== 16'h0) $display("FAIL reset_dq2 got %h want 0000", dq2); else pass_cnt++;
    total_cnt++; if (we2 !== 1'b0) $display("FAIL reset_wren got %b want 0", we2); else pass_cnt++;
    total_cnt++; if (ra2 !== 8'h00) $display("FAIL reset_ramaddr got %h want 00", ra2); else pass_cnt++;
    total_cnt++; if (rd2 !== 8'h00) $display("FAIL reset_ramdin got %h want 00", rd2); else pass_cnt++;
    total_cnt++; if (acq4 !== 4'h0 || dq4 !== 32'h0) $display("FAIL reset_d4 got acq %h dq %h want 0/0", acq4, dq4); else pass_cnt++;
  endtask

  task automatic test_single_read;
    rden2 = 2'b01; addr2[0] = 8'h10;
    tick; // cycle 1: ACCESS
    total_cnt++; if (ra2 !== 8'h10) $display("FAIL read_addr got %h want 10", ra2); else pass_cnt++;
    total_cnt++; if (we2 !== 1'b0 || acq2 !== 2'b00) $display("FAIL read_c1 got we %b acq %b want 0/00", we2, acq2); else pass_cnt++;
    tick; // cycle 2: CAPTURE
    total_cnt++; if (we2 !== 1'b0 || acq2 !== 2'b00) $display("FAIL read_c2 got we %b acq %b want 0/00", we2, acq2); else pass_cnt++;
    tick; // cycle 3: completion
    total_cnt++; if (acq2 !== 2'b01) $display("FAIL read_acq got %b want 01", acq2); else pass_cnt++;
    total_cnt++; if (dq2[0] !== 8'hA5) $display("FAIL read_dq0 got %h want a5", dq2[0]); else pass_cnt++;
    rden2 = 2'b00;
    tick;
    total_cnt++; if (acq2 !== 2'b00 || we2 !== 1'b0) $display("FAIL read_c4 got acq %b we %b want 00/0", acq2, we2); else pass_cnt++;
    total_cnt++; if (dq2[0] !== 8'hA5) $display("FAIL read_hold got %h want a5", dq2[0]); else pass_cnt++;
  endtask

  task automatic test_write_readback;
    wren2 = 2'b10; addr2[1] = 8'h22; din2[1] = 8'h3C;
    tick; // cycle 1
    total_cnt++; if (we2 !== 1'b1 || ra2 !== 8'h22 || rd2 !== 8'h3C)
      $display("FAIL wr_access got we %b a %h d %h want 1/22/3c", we2, ra2, rd2); else pass_cnt++;
    total_cnt++; if (acq2 !== 2'b00) $display("FAIL wr_c1_acq got %b want 00", acq2); else pass_cnt++;
    tick; // cycle 2
    total_cnt++; if (acq2 !== 2'b10 || we2 !== 1'b0) $display("FAIL wr_acq got acq %b we %b want 10/0", acq2, we2); else pass_cnt++;
    total_cnt++; if (mem2[8'h22] !== 8'h3C) $display("FAIL wr_mem got %h want 3c", mem2[8'h22]); else pass_cnt++;
    wren2 = 2'b00;
    tick;
    total_cnt++; if (acq2 !== 2'b00) $display("FAIL wr_c3_acq got %b want 00", acq2); else pass_cnt++;
    rden2 = 2'b10;
    tick; tick; tick;
    total_cnt++; if (acq2 !== 2'b10 || dq2[1] !== 8'h3C) $display("FAIL rb_dq1 got acq %b dq1 %h want 10/3c", acq2, dq2[1]); else pass_cnt++;
    total_cnt++; if (dq2[0] !== 8'hA5) $display("FAIL rb_dq0 got %h want a5", dq2[0]); else pass_cnt++;
    rden2 = 2'b00;
    tick;
  endtask

  task automatic test_rw_both;
    rden2 = 2'b01; wren2 = 2'b01; addr2[0] = 8'h30; din2[0] = 8'h77;
    tick;
    total_cnt++; if (we2 !== 1'b1 || ra2 !== 8'h30) $display("FAIL both_wren got we %b a %h want 1/30", we2, ra2); else pass_cnt++;
    tick;
    total_cnt++; if (acq2 !== 2'b01) $display("FAIL both_acq got %b want 01", acq2); else pass_cnt++;
    total_cnt++; if (dq2[0] !== 8'hA5 || mem2[8'h30] !== 8'h77)
      $display("FAIL both_data got dq0 %h mem %h want a5/77", dq2[0], mem2[8'h30]); else pass_cnt++;
    rden2 = 2'b00; wren2 = 2'b00;
    tick;
  endtask

  task automatic test_contention;
    int order[$];
    int exp_order [6];
    logic [3:0] prev;
`ifdef DRAM_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0, 1};
`endif
    for (int i = 0; i < 4; i++) addr4[i] = 8'h40 + 8'(i);
    rden4 = 4'hF;
    prev  = 4'h0;
    for (int n = 1; n <= 19; n++) begin
      tick;
      if (acq4 !== 4'h0) begin
        total_cnt++;
        if (!$onehot(acq4) || (acq4 & prev) !== 4'h0)
          $display("FAIL cont_pulse cycle %0d got %b prev %b want one-hot single", n, acq4, prev);
        else pass_cnt++;
        order.push_back($clog2(acq4));
      end
      prev = acq4;
    end
    total_cnt++; if (order.size() !== 6) $display("FAIL cont_count got %0d want 6", order.size()); else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      if (i < order.size()) begin
        total_cnt++;
        if (order[i] !== exp_order[i]) $display("FAIL cont_order[%0d] got %0d want %0d", i, order[i], exp_order[i]);
        else pass_cnt++;
      end
    end
`ifndef DRAM_ARB_FIXED_PRIO_EN
    total_cnt++; if (dq4 !== {8'hB3, 8'hB2, 8'hB1, 8'hB0}) $display("FAIL cont_dq got %h want b3b2b1b0", dq4); else pass_cnt++;
`endif
    rden4 = 4'h0;
    tick; tick; tick; tick;
  endtask

  task automatic test_rst_mid_write;
    wren2 = 2'b10; addr2[1] = 8'h50; din2[1] = 8'h55;
    tick; // ACCESS of the write
    rst = 1'b1;
    #1;
    total_cnt++; if (we2 !== 1'b0) $display("FAIL rst_wren got %b want 0", we2); else pass_cnt++;
    tick;
    rst = 1'b0; wren2 = 2'b00;
    total_cnt++; if (acq2 !== 2'b00 || dq2 !== 16'h0) $display("FAIL rst_state got acq %b dq %h want 00/0000", acq2, dq2); else pass_cnt++;
    tick;
    total_cnt++; if (acq2 !== 2'b00) $display("FAIL rst_noacq got %b want 00", acq2); else pass_cnt++;
    total_cnt++; if (mem2[8'h50] !== 8'h11) $display("FAIL rst_mem got %h want 11", mem2[8'h50]); else pass_cnt++;
    rden2 = 2'b11; addr2[0] = 8'h10; addr2[1] = 8'h22;
    tick;
    total_cnt++; if (ra2 !== 8'h10) $display("FAIL rst_first_grant got addr %h want 10", ra2); else pass_cnt++;
    tick; tick;
    total_cnt++; if (acq2 !== 2'b01 || dq2[0] !== 8'hA5) $display("FAIL rst_first_acq got acq %b dq0 %h want 01/a5", acq2, dq2[0]); else pass_cnt++;
    rden2 = 2'b00;
    tick;
  endtask

`ifdef DRAM_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio;
    int bad;
    int seen1;
    bad = 0;
    rden2 = 2'b11; addr2[0] = 8'h10; addr2[1] = 8'h22;
    for (int n = 0; n < 12; n++) begin
      tick;
      if (acq2[1]) bad++;
    end
    total_cnt++; if (bad !== 0) $display("FAIL fixed_starve got %0d core1 acqs want 0", bad); else pass_cnt++;
    rden2 = 2'b10;
    seen1 = 0;
    for (int n = 0; n < 8; n++) begin
      tick;
      if (acq2[1]) seen1++;
    end
    total_cnt++; if (seen1 == 0) $display("FAIL fixed_release got %0d core1 acqs want >0", seen1); else pass_cnt++;
    rden2 = 2'b00;
    tick; tick; tick;
  endtask
`endif

  initial begin
    test_reset;
    test_single_read;
    test_write_readback;
    test_rw_both;
    test_contention;
    test_rst_mid_write;
`ifdef DRAM_ARB_FIXED_PRIO_EN
    test_fixed_prio;
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
